uart_host_bus_master: RTL
=========================

Name: uart_host_bus_master

Overview:
- Bus initiator for the UART transceiver's byte-wide chip-select/read-strobe interface (cs_n, rd_n, shared data bus).
- Converts transceiver events into host-side FIFO traffic:
  - got_data is turned into bus read cycles that fill an RX FIFO.
  - Bytes pushed into a TX FIFO are written to the transceiver, paced by tx_idle and tx_ok.
- Sits between the transceiver and the motion-control command logic, all in the system clock domain.

Parameters:
- FIFO_AW, 4, log2 of RX and TX FIFO depth (16 entries each).
- RD_CYCLES, 2, clocks cs_n/rd_n are held low per read; minimum 2.
- WR_CYCLES, 2, clocks cs_n low with rd_n high per write; minimum 1.
- TX_TIMEOUT, 32'd1024, clocks to wait for synchronized tx_idle to fall after a write strobe.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cs_n  out  1  transceiver chip select, active low
- rd_n  out  1  low means read cycle; high while cs_n low means write cycle
- data  inout  8  shared bus; driven by this block only during write cycles, else high-Z
- got_data  in  1  transceiver byte-received flag (asynchronous to clk)
- tx_idle  in  1  transceiver transmitter idle (asynchronous)
- tx_ok  in  1  transceiver transmit-finished flag (asynchronous)
- tx_wdata  in  8  host byte to send
- tx_wr  in  1  push tx_wdata; ignored when tx_full
- tx_full  out  1  TX FIFO full
- rx_rdata  out  8  head of RX FIFO, valid when !rx_empty
- rx_rd  in  1  pop RX FIFO; ignored when rx_empty
- rx_empty  out  1  RX FIFO empty
- rx_ovf  out  1  sticky: received byte dropped because RX FIFO was full
- tx_err  out  1  sticky: tx_idle never fell within TX_TIMEOUT

Behaviour:
- Reset values:
  - cs_n=1, rd_n=1, data=Z.
  - Both FIFOs empty: tx_full=0, rx_empty=1, rx_rdata=0.
  - rx_ovf=0, tx_err=0.
  - FSM in IDLE; synchronizers and rx_pend cleared.
- Reset mid-cycle aborts any bus cycle within one clock (cs_n=1, data=Z) and flushes both FIFOs.
- Synchronization:
  - got_data, tx_idle and tx_ok each pass through a 2-flop synchronizer.
  - got_data and tx_ok are rising-edge detected on the synchronized value.
  - A got_data edge sets rx_pend. rx_pend clears when a read capture completes.
- FSM states:
  - IDLE:
    - If rx_pend, go to RD (priority).
    - Else if TX FIFO is non-empty and synchronized tx_idle=1, go to WR; the FIFO head is latched into the output data register.
  - RD:
    - cs_n=0, rd_n=0 for RD_CYCLES clocks.
    - data is sampled on the last of these clocks.
    - Next clock: cs_n=1, rd_n=1, push the sample to the RX FIFO, clear rx_pend.
    - If the RX FIFO is full, the byte is dropped and rx_ovf is set.
    - Return to the saved state: IDLE, WAIT_BUSY or WAIT_DONE.
  - WR:
    - cs_n=0, rd_n=1, data driven for WR_CYCLES clocks.
    - Then release the bus, pop the TX FIFO, clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY:
    - Wait for synchronized tx_idle=0, then go to WAIT_DONE.
    - If the counter reaches TX_TIMEOUT-1 first, set tx_err and go to IDLE; the byte is lost.
    - A tx_ok edge seen here also completes the byte and returns to IDLE.
  - WAIT_DONE:
    - Wait for a tx_ok edge or synchronized tx_idle=1, then go to IDLE.
  - In WAIT_BUSY and WAIT_DONE, rx_pend preempts: go to RD with the return state saved. The timeout counter keeps running during the preempting read.
- Bus rules:
  - The data output enable equals (state==WR).
  - Never drive data while rd_n=0.
  - cs_n is high for at least one clock between consecutive bus cycles.
- FIFO rules:
  - Simultaneous push and pop on a full or empty FIFO: a pop on empty or a push on full is ignored; the other operation proceeds.
  - Simultaneous push and pop on a partially full FIFO leaves the count unchanged.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
  - rx_rdata is first-word-fall-through.
- Event rules:
  - A got_data edge arriving while rx_pend is already set is merged. The earlier byte is already overwritten in the transceiver; it is not flagged.
  - Sticky flags clear only on rst.

Decomposition:
- Package uart_host_pkg holds:
  - the state enumeration (IDLE, RD, WR, WAIT_BUSY, WAIT_DONE);
  - the byte width constant 8;
  - the default TX_TIMEOUT.
- One sub-module, uart_host_fifo, a parameterized synchronous FWFT FIFO (width 8, depth 2**FIFO_AW, full/empty outputs).
  - It is instantiated twice, once for RX and once for TX.
- Synchronizers and the FSM stay in the top module.

Test Plan:
- Read path:
  - Stimulus: transceiver model presents 8'hA5 and pulses got_data.
  - Response: cs_n=0/rd_n=0 for exactly 2 clocks within 4 clocks of the pulse, data never driven by the DUT, rx_empty drops, rx_rdata=8'hA5.
- Write path:
  - Stimulus: push 8'h3C with tx_idle=1; the model drops tx_idle 3 clocks after the write, then pulses tx_ok.
  - Response: exactly one 2-clock write cycle with data=8'h3C, FSM back in IDLE after tx_ok, tx_full=0.
- Back-to-back writes:
  - Stimulus: push 8'h01, 8'h02, 8'h03.
  - Response: three write cycles in order, no second write before tx_ok of the previous byte.
- Preemption:
  - Stimulus: got_data pulse with 8'h5A during WAIT_DONE of a pending write.
  - Response: read cycle completes, rx_rdata=8'h5A, then the FSM waits for tx_ok; no extra write cycle.
- RX overflow:
  - Stimulus: 17 got_data pulses with no rx_rd.
  - Response: 16 entries kept in order, 17th dropped, rx_ovf=1.
  - Stimulus: then assert rst for 1 clock.
  - Response: rx_ovf=0, rx_empty=1.
- TX timeout:
  - Stimulus: push a byte with tx_idle held at 1 forever.
  - Response: tx_err=1 at TX_TIMEOUT clocks after the strobe, state IDLE, next TX byte still served.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host bus master.
package uart_host_pkg;

    localparam int BYTE_W = 8;
    localparam logic [31:0] TX_TIMEOUT_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD        = 3'd1,
        WR        = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous first-word-fall-through byte FIFO, depth 2**AW.
module uart_host_fifo
    import uart_host_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              push,
    input  logic              pop,
    output logic [BYTE_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 2 ** AW;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       wr_ptr_next, rd_ptr_next;
    logic [BYTE_W-1:0] rdata_reg;
    logic              do_push, do_pop;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign wr_ptr_next = wr_ptr_reg + (AW+1)'(do_push);
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);
    assign rdata       = rdata_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Head register tracks the next read pointer; a write landing on the
    // new head (FIFO empty after this clock's pop) is bypassed straight in.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_host_bus_master.sv
// Bus initiator for the UART transceiver: got_data becomes read cycles into an
// RX FIFO, TX FIFO bytes become write cycles paced by tx_idle / tx_ok.
module uart_host_bus_master
    import uart_host_pkg::*;
#(
    parameter int          FIFO_AW    = 4,
    parameter int          RD_CYCLES  = 2,
    parameter int          WR_CYCLES  = 2,
    parameter logic [31:0] TX_TIMEOUT = TX_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cs_n,
    output logic              rd_n,
    inout  wire  [BYTE_W-1:0] data,
    input  logic              got_data,
    input  logic              tx_idle,
    input  logic              tx_ok,
    input  logic [BYTE_W-1:0] tx_wdata,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic [BYTE_W-1:0] rx_rdata,
    input  logic              rx_rd,
    output logic              rx_empty,
    output logic              rx_ovf,
    output logic              tx_err
);
    state_t            state_reg, state_next, ret_reg, ret_next;
    logic [7:0]        cyc_cnt_reg;
    logic [31:0]       to_cnt_reg;
    logic [BYTE_W-1:0] wdata_reg, tx_head;
    logic              rx_pend_reg, rx_ovf_reg, tx_err_reg;
    logic              got_prev_reg, ok_prev_reg;
    logic [2:0]        async_in, sync_v;
    logic              got_edge, ok_edge, idle_s;
    logic              rd_last, wr_last, to_hit, tx_timeout;
    logic              tx_empty, rx_full, data_oe, rx_push, tx_pop;

    assign async_in = {tx_ok, tx_idle, got_data};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg, sync_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_v[gi] = sync_reg;
        end
    endgenerate

    assign got_edge   = sync_v[0] && !got_prev_reg;
    assign idle_s     = sync_v[1];
    assign ok_edge    = sync_v[2] && !ok_prev_reg;
    assign rd_last    = (state_reg == RD) && (cyc_cnt_reg == 8'(RD_CYCLES - 1));
    assign wr_last    = (state_reg == WR) && (cyc_cnt_reg == 8'(WR_CYCLES - 1));
    assign to_hit     = (to_cnt_reg >= TX_TIMEOUT - 32'd1);
    assign tx_timeout = (state_reg == WAIT_BUSY) && !rx_pend_reg && !ok_edge &&
                        idle_s && to_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ret_reg      <= IDLE;
            cyc_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            wdata_reg    <= '0;
            rx_pend_reg  <= 1'b0;
            rx_ovf_reg   <= 1'b0;
            tx_err_reg   <= 1'b0;
            got_prev_reg <= 1'b0;
            ok_prev_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ret_reg      <= ret_next;
            got_prev_reg <= sync_v[0];
            ok_prev_reg  <= sync_v[2];
            if (state_next != state_reg) begin
                cyc_cnt_reg <= '0;
            end else if (state_reg == RD || state_reg == WR) begin
                cyc_cnt_reg <= cyc_cnt_reg + 8'd1;
            end
            // The timeout keeps counting while a read preempts WAIT_BUSY.
            if (wr_last) begin
                to_cnt_reg <= '0;
            end else if (state_reg == WAIT_BUSY ||
                         (state_reg == RD && ret_reg == WAIT_BUSY)) begin
                to_cnt_reg <= to_cnt_reg + 32'd1;
            end
            if (state_reg == IDLE && state_next == WR) begin
                wdata_reg <= tx_head;
            end
            if (got_edge) begin
                rx_pend_reg <= 1'b1;
            end else if (rd_last) begin
                rx_pend_reg <= 1'b0;
            end
            if (rd_last && rx_full) begin
                rx_ovf_reg <= 1'b1;
            end
            if (tx_timeout) begin
                tx_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        case (state_reg)
            IDLE: begin
                if (rx_pend_reg) begin
                    state_next = RD;
                    ret_next   = IDLE;
                end else if (!tx_empty && idle_s) begin
                    state_next = WR;
                end
            end
            RD:        if (rd_last) state_next = ret_reg;
            WR:        if (wr_last) state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (rx_pend_reg) begin
                    state_next = RD;
                    ret_next   = WAIT_BUSY;
                end else if (ok_edge || tx_timeout) begin
                    state_next = IDLE;
                end else if (!idle_s) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rx_pend_reg) begin
                    state_next = RD;
                    ret_next   = WAIT_DONE;
                end else if (ok_edge || idle_s) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        data_oe = 1'b0;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        case (state_reg)
            RD: begin
                cs_n    = 1'b0;
                rd_n    = 1'b0;
                rx_push = rd_last;
            end
            WR: begin
                cs_n    = 1'b0;
                data_oe = 1'b1;
                tx_pop  = wr_last;
            end
            default: ;
        endcase
    end

    assign data   = data_oe ? wdata_reg : {BYTE_W{1'bz}};
    assign rx_ovf = rx_ovf_reg;
    assign tx_err = tx_err_reg;

    uart_host_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .srst  (rst),
        .wdata (data),
        .push  (rx_push),
        .pop   (rx_rd),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_host_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .srst  (rst),
        .wdata (tx_wdata),
        .push  (tx_wr),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

endmodule
